// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
// Module   : seq_div
// Purpose  : 16/8 unsigned restoring divider, one quotient bit per clock,
//            with divide-by-zero trap and seven-segment state display.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        done_flag,
    output logic        div_zero,
    output logic [15:0] quotient_out,
    output logic [7:0]  remainder_out,
    output logic [6:0]  seven_seg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'd15;

    state_t      state, state_nxt;
    logic        accept;
    logic [15:0] dvd_r;
    logic [7:0]  dsr_r;
    logic [8:0]  rem_r;
    logic [14:0] quo_r;
    logic [3:0]  cnt_r;

    logic [9:0]  shifted;
    logic        qbit;
    logic [8:0]  rem_nxt;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_r, dvd_r[15]};
        qbit    = (shifted >= {2'b00, dsr_r});
        rem_nxt = 9'(qbit ? (shifted - {2'b00, dsr_r}) : shifted);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == 8'd0) ? ERR : CALC;
                end
            end
            CALC: begin
                if (cnt_r == LAST_ITER) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            dvd_r         <= '0;
            dsr_r         <= '0;
            rem_r         <= '0;
            quo_r         <= '0;
            cnt_r         <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
            done_flag     <= 1'b0;
            div_zero      <= 1'b0;
        end else if (accept) begin
            dvd_r <= dividend;
            dsr_r <= divisor;
            rem_r <= '0;
            quo_r <= '0;
            cnt_r <= '0;
            if (divisor == 8'd0) begin
                quotient_out  <= 16'hFFFF;
                remainder_out <= 8'hFF;
                done_flag     <= 1'b1;
                div_zero      <= 1'b1;
            end else begin
                done_flag <= 1'b0;
                div_zero  <= 1'b0;
            end
        end else if (state == CALC) begin
            dvd_r <= {dvd_r[14:0], 1'b0};
            rem_r <= rem_nxt;
            quo_r <= {quo_r[13:0], qbit};
            cnt_r <= cnt_r + 4'd1;
            // Results become visible only on the final iteration edge.
            if (cnt_r == LAST_ITER) begin
                quotient_out  <= {quo_r, qbit};
                remainder_out <= rem_nxt[7:0];
                done_flag     <= 1'b1;
                div_zero      <= 1'b0;
            end
        end
    end

    always_comb begin
        seven_seg = 7'b0000000;
        case (state)
            IDLE:    seven_seg = 7'b0111111;
            CALC:    seven_seg = 7'b0000110;
            DONE:    seven_seg = 7'b1011011;
            ERR:     seven_seg = 7'b1001111;
            default: seven_seg = 7'b0000000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div
// Purpose  : Self-checking bench for seq_div against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        done_flag, div_zero;
    logic [15:0] quotient_out;
    logic [7:0]  remainder_out;
    logic [6:0]  seven_seg;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] SEG_IDLE = 7'b0111111;
    localparam logic [6:0] SEG_CALC = 7'b0000110;
    localparam logic [6:0] SEG_DONE = 7'b1011011;
    localparam logic [6:0] SEG_ERR  = 7'b1001111;

    seq_div dut (
        .clk           (clk),
        .reset_a       (reset_a),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .done_flag     (done_flag),
        .div_zero      (div_zero),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .seven_seg     (seven_seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns edges from acceptance until done_flag is seen.
    task automatic launch(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output logic [6:0] seg0, output logic [15:0] q0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seg0  = seven_seg;
        q0    = quotient_out;
        lat   = 0;
        while (!done_flag && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        if (b == 8'd0) begin
            eq = 16'hFFFF;
            er = 8'hFF;
        end else begin
            eq = a / 16'(b);
            er = 8'(a % 16'(b));
        end
        chk({tag, "_q"},    32'(quotient_out),  32'(eq));
        chk({tag, "_r"},    32'(remainder_out), 32'(er));
        chk({tag, "_dz"},   32'(div_zero),      32'(b == 8'd0));
        chk({tag, "_done"}, 32'(done_flag),     32'd1);
    endtask

    initial begin
        int          lat;
        logic [6:0]  seg0;
        logic [15:0] q0;
        logic [15:0] a;
        logic [7:0]  b;

        // Reset state, before any clock edge
        #3;
        chk("rst_q",    32'(quotient_out),  32'd0);
        chk("rst_r",    32'(remainder_out), 32'd0);
        chk("rst_done", 32'(done_flag),     32'd0);
        chk("rst_dz",   32'(div_zero),      32'd0);
        chk("rst_seg",  32'(seven_seg),     32'(SEG_IDLE));
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);

        // 1000 / 7
        launch(16'd1000, 8'd7, lat, seg0, q0);
        chk("d1000_lat",  32'(lat),  32'd16);
        chk("d1000_cseg", 32'(seg0), 32'(SEG_CALC));
        check_result("d1000", 16'd1000, 8'd7);
        chk("d1000_q142", 32'(quotient_out), 32'd142);
        chk("d1000_seg",  32'(seven_seg),    32'(SEG_DONE));

        // FFFF / 1, then back-to-back 0 / 5 from DONE
        launch(16'hFFFF, 8'd1, lat, seg0, q0);
        chk("ffff_lat", 32'(lat), 32'd16);
        check_result("ffff", 16'hFFFF, 8'd1);
        launch(16'd0, 8'd5, lat, seg0, q0);
        chk("b2b_hold_q", 32'(q0),   32'hFFFF);
        chk("b2b_cseg",   32'(seg0), 32'(SEG_CALC));
        chk("b2b_lat",    32'(lat),  32'd16);
        check_result("b2b", 16'd0, 8'd5);

        // Divide by zero
        launch(16'd200, 8'd0, lat, seg0, q0);
        chk("dz_lat", 32'(lat),  32'd0);
        chk("dz_seg", 32'(seg0), 32'(SEG_ERR));
        check_result("dz", 16'd200, 8'd0);

        // 50000 / 255 with start held and operands scrambled during CALC
        dividend = 16'd50000;
        divisor  = 8'd255;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_dz_clear", 32'(div_zero),  32'd0);
        chk("hold_dn_clear", 32'(done_flag), 32'd0);
        lat = 0;
        while (!done_flag && lat < 40) begin
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("hold_lat", 32'(lat), 32'd16);
        check_result("hold", 16'd50000, 8'd255);
        chk("hold_q196", 32'(quotient_out), 32'd196);

        // Asynchronous reset in the middle of CALC
        dividend = 16'd40000;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset_a = 1'b1;
        #1;
        chk("arst_q",    32'(quotient_out),  32'd0);
        chk("arst_r",    32'(remainder_out), 32'd0);
        chk("arst_done", 32'(done_flag),     32'd0);
        chk("arst_dz",   32'(div_zero),      32'd0);
        chk("arst_seg",  32'(seven_seg),     32'(SEG_IDLE));
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);
        chk("arst_idle_seg", 32'(seven_seg), 32'(SEG_IDLE));
        launch(16'd77, 8'd3, lat, seg0, q0);
        chk("d77_lat", 32'(lat), 32'd16);
        check_result("d77", 16'd77, 8'd3);

        // Random regression, back-to-back, with forced zero and oversized divisors
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 7))
                0: begin a = 16'($urandom); b = 8'd0; end
                1: begin b = 8'($urandom_range(2, 255)); a = 16'($urandom_range(0, int'(b) - 1)); end
                default: begin a = 16'($urandom); b = 8'($urandom); end
            endcase
            launch(a, b, lat, seg0, q0);
            chk("rnd_lat", 32'(lat), (b == 8'd0) ? 32'd0 : 32'd16);
            check_result("rnd", a, b);
            if (b != 8'd0)
                chk("rnd_ident", 32'(quotient_out) * 32'(b) + 32'(remainder_out), 32'(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
